// File: rtl/core_pkg.sv
// Shared decode-stage types: immediate format encodings and machine word width.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      IMM_I     = 3'd0,
      IMM_S     = 3'd1,
      IMM_B     = 3'd2,
      IMM_U     = 3'd3,
      IMM_J     = 3'd4,
      IMM_SHAMT = 3'd5,
      IMM_ZIMM  = 3'd6,
      IMM_UI    = 3'd7
   } imm_fmt_e;

endpackage

// File: rtl/extend_dec.sv
// Combinational immediate format mux: pure bit selection and sign/zero extension.
module extend_dec
   import core_pkg::*;
(
   input  logic [2:0]      ex_xon,
   input  logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] imm
);

   imm_fmt_e fmt;
   logic     sign;
   logic     unused_opcode;

   assign fmt           = imm_fmt_e'(ex_xon);
   assign sign          = inst[31];
   assign unused_opcode = ^inst[6:0];

   // Every one of the eight codes is a real format, so the case is full.
   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I:     imm = {{20{sign}}, inst[31:20]};
         IMM_S:     imm = {{20{sign}}, inst[31:25], inst[11:7]};
         IMM_B:     imm = {{19{sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:     imm = {inst[31:12], 12'h000};
         IMM_J:     imm = {{11{sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         IMM_SHAMT: imm = {27'd0, inst[24:20]};
         IMM_ZIMM:  imm = {27'd0, inst[19:15]};
         IMM_UI:    imm = {20'd0, inst[31:20]};
         default:   imm = '0;
      endcase
   end

endmodule

// File: rtl/extend.sv
// Immediate generator; define EXTEND_PIPE_EN for the registered output stage,
// otherwise out/out_valid are combinational and clk/rst_n are unused.
module extend
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [2:0]      ex_xon,
   input  logic [XLEN-1:0] inst,
   output logic            out_valid,
   output logic [XLEN-1:0] out
);

   logic [XLEN-1:0] imm;

   extend_dec u_dec (
      .ex_xon (ex_xon),
      .inst   (inst),
      .imm    (imm)
   );

`ifdef EXTEND_PIPE_EN
   // The immediate only updates on valid cycles so it holds across bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out <= imm;
         end
      end
   end
`else
   logic unused_clk_rst;

   assign unused_clk_rst = clk ^ rst_n;
   assign out            = imm;
   assign out_valid      = in_valid;
`endif

endmodule

// File: tb/tb_extend.sv
// Self-checking bench for extend: directed vectors plus random formats against
// an arithmetic reference model; adapts to the EXTEND_PIPE_EN build.
module tb_extend;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [2:0]  ex_xon;
   logic [31:0] inst;
   logic        out_valid;
   logic [31:0] out;

   int total = 0;
   int bad   = 0;

   logic [31:0] expOut;
   logic        expValid;

   extend dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .ex_xon    (ex_xon),
      .inst      (inst),
      .out_valid (out_valid),
      .out       (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic longint field(input logic [31:0] i, input int hi, input int lo);
      longint u;
      u = longint'(i);
      return (u >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
   endfunction

   function automatic longint sext(input longint v, input int bits);
      return (v >= (longint'(1) << (bits - 1))) ? v - (longint'(1) << bits) : v;
   endfunction

   // Reference: rebuild each immediate's numeric value and reinterpret its sign.
   function automatic logic [31:0] refImm(input logic [2:0] sel, input logic [31:0] i);
      longint r;
      case (sel)
         3'd0: r = sext(field(i, 31, 20), 12);
         3'd1: r = sext(field(i, 31, 25) * 32 + field(i, 11, 7), 12);
         3'd2: r = sext(field(i, 31, 31) * 4096 + field(i, 7, 7) * 2048
                        + field(i, 30, 25) * 32 + field(i, 11, 8) * 2, 13);
         3'd3: r = field(i, 31, 12) * 4096;
         3'd4: r = sext(field(i, 31, 31) * (longint'(1) << 20) + field(i, 19, 12) * 4096
                        + field(i, 20, 20) * 2048 + field(i, 30, 21) * 2, 21);
         3'd5: r = field(i, 24, 20);
         3'd6: r = field(i, 19, 15);
         default: r = field(i, 31, 20);
      endcase
      return r[31:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Drive one input set, wait for it to reach the output, then check both outputs.
   task automatic applyStimulus(input string tag, input logic v, input logic [2:0] sel,
                                input logic [31:0] word, input bit useConst,
                                input logic [31:0] constExp);
      logic [31:0] want;
      @(negedge clk);
      in_valid = v;
      ex_xon   = sel;
      inst     = word;
      want     = useConst ? constExp : refImm(sel, word);
`ifdef EXTEND_PIPE_EN
      @(posedge clk);
      #1;
      expValid = v;
      if (v) expOut = want;
`else
      #1;
      expValid = v;
      expOut   = want;
`endif
      checkOutput({tag, ".out"}, out, expOut);
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, expValid});
   endtask

   initial begin
      logic [2:0]  rsel;
      logic [31:0] rinst;
      logic        rv;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      ex_xon   = 3'd0;
      inst     = 32'd0;
      expOut   = 32'd0;
      expValid = 1'b0;
      #12;
      checkOutput("reset.out", out, 32'd0);
      checkOutput("reset.valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("i_pos",    1'b1, 3'd0, 32'h03001111, 1'b1, 32'h00000030);
      applyStimulus("s_pos",    1'b1, 3'd1, 32'h04001111, 1'b1, 32'h00000042);
      applyStimulus("b_pos",    1'b1, 3'd2, 32'h15001111, 1'b1, 32'h00000142);
      applyStimulus("u",        1'b1, 3'd3, 32'h06001235, 1'b1, 32'h06001000);
      applyStimulus("j_pos",    1'b1, 3'd4, 32'h07004341, 1'b1, 32'h00004070);
      applyStimulus("shamt",    1'b1, 3'd5, 32'h08001111, 1'b1, 32'h00000000);
      applyStimulus("zimm",     1'b1, 3'd6, 32'h000F8073, 1'b1, 32'h0000001F);
      applyStimulus("ui",       1'b1, 3'd7, 32'h0A501111, 1'b1, 32'h000000A5);
      applyStimulus("i_neg",    1'b1, 3'd0, 32'hFFF00093, 1'b1, 32'hFFFFFFFF);
      applyStimulus("ui_max",   1'b1, 3'd7, 32'hFFF00093, 1'b1, 32'h00000FFF);
      applyStimulus("shamt_mx", 1'b1, 3'd5, 32'hFFF00093, 1'b1, 32'h0000001F);

      applyStimulus("load_ui",  1'b1, 3'd7, 32'h0A501111, 1'b1, 32'h000000A5);
      applyStimulus("hold",     1'b0, 3'd0, 32'hFFF00093, 1'b0, 32'd0);

`ifdef EXTEND_PIPE_EN
      applyStimulus("reload",   1'b1, 3'd7, 32'h0A501111, 1'b1, 32'h000000A5);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst.out", out, 32'd0);
      checkOutput("midrst.valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      expOut   = 32'd0;
      expValid = 1'b0;
      applyStimulus("post_rst_idle", 1'b0, 3'd3, 32'h12345678, 1'b0, 32'd0);
      applyStimulus("post_rst_first", 1'b1, 3'd3, 32'h12345678, 1'b1, 32'h12345000);
`endif

      for (int s = 0; s < 8; s++) begin
         applyStimulus($sformatf("b2b%0d", s), 1'b1, 3'(s), $urandom, 1'b0, 32'd0);
      end

      for (int n = 0; n < 300; n++) begin
         rsel  = 3'($urandom_range(0, 7));
         rinst = $urandom;
         rv    = ($urandom_range(0, 3) != 0);
         applyStimulus($sformatf("rnd%0d_sel%0d", n, rsel), rv, rsel, rinst, 1'b0, 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
